// File: rtl/iter_divider.sv
// Iterative radix-2 restoring divider producing quotient and remainder for
// signed or unsigned operands, with divide-by-zero and small-dividend fast paths.
module iter_divider #(
  parameter int WIDTH     = 32,
  parameter bit EARLY_OUT = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  input  logic             flush,
  output logic             is_running,
  output logic             done,
  output logic [WIDTH-1:0] quotient_out,
  output logic [WIDTH-1:0] remainder_out,
  output logic [1:0]       state_dbg
);

  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  // Handshake: start is a request strobe honoured only when the block is in
  // IDLE or DONE and flush is low; done is a one-cycle valid for the results.
  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] rem;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH-1:0] dvd_raw;
  logic             neg_q;
  logic             neg_r;
  logic             div_zero;
  logic             early;

  logic             is_signed;
  logic [WIDTH-1:0] dvd_abs;
  logic [WIDTH-1:0] dvs_abs;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             accept;
  logic [WIDTH-1:0] q_fix;
  logic [WIDTH-1:0] r_fix;
  logic             unused_op;

  assign unused_op = op[0];

  always_comb begin
    is_signed = ~op[1];
    dvd_abs   = (is_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dvs_abs   = (is_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    accept    = start && !flush && (state == IDLE || state == DONE);
    // Shift the next dividend bit into the partial remainder and trial-subtract.
    trial     = {rem, quo[WIDTH-1]};
    diff      = trial - {1'b0, dvs_mag};
    q_fix     = neg_q ? -quo : quo;
    r_fix     = neg_r ? -rem : rem;
  end

  assign is_running = (state == CALC) || (state == FIX);
  assign state_dbg  = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      quo           <= '0;
      rem           <= '0;
      dvs_mag       <= '0;
      dvd_raw       <= '0;
      neg_q         <= 1'b0;
      neg_r         <= 1'b0;
      div_zero      <= 1'b0;
      early         <= 1'b0;
      done          <= 1'b0;
      quotient_out  <= '0;
      remainder_out <= '0;
    end else begin
      done <= 1'b0;
      if (flush) begin
        state <= IDLE;
      end else begin
        case (state)
          IDLE, DONE: begin
            if (accept) begin
              state    <= CALC;
              cnt      <= '0;
              quo      <= dvd_abs;
              rem      <= '0;
              dvs_mag  <= dvs_abs;
              dvd_raw  <= dividend;
              neg_q    <= is_signed && (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
              neg_r    <= is_signed && dividend[WIDTH-1];
              div_zero <= (divisor == '0);
              early    <= EARLY_OUT && (dvd_abs < dvs_abs);
            end else begin
              state <= IDLE;
            end
          end
          CALC: begin
            if (div_zero || early) begin
              // Both fast paths hand back the original dividend as remainder.
              state         <= DONE;
              done          <= 1'b1;
              quotient_out  <= div_zero ? '1 : '0;
              remainder_out <= dvd_raw;
            end else begin
              if (!diff[WIDTH]) begin
                rem <= diff[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b1};
              end else begin
                rem <= trial[WIDTH-1:0];
                quo <= {quo[WIDTH-2:0], 1'b0};
              end
              cnt <= cnt + 1'b1;
              if (cnt == CW'(WIDTH - 1)) state <= FIX;
            end
          end
          FIX: begin
            state         <= DONE;
            done          <= 1'b1;
            quotient_out  <= q_fix;
            remainder_out <= r_fix;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_iter_divider.sv
// Randomized and directed bench for iter_divider at WIDTH=32, checked against
// an arithmetic reference model and an expected-result queue.
module tb_iter_divider;

  localparam int W = 32;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic [1:0]   op;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         flush;
  logic         is_running;
  logic         done;
  logic [W-1:0] quotient_out;
  logic [W-1:0] remainder_out;
  logic [1:0]   state_dbg;

  int checks;
  int failures;
  logic [2*W-1:0] exp_q[$];
  logic [W-1:0]   last_q;
  logic [W-1:0]   last_r;

  iter_divider #(.WIDTH(W), .EARLY_OUT(1'b1)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .op(op),
    .dividend(dividend),
    .divisor(divisor),
    .flush(flush),
    .is_running(is_running),
    .done(done),
    .quotient_out(quotient_out),
    .remainder_out(remainder_out),
    .state_dbg(state_dbg)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer division; fast paths finish in 2 cycles, else W+2.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                input logic [1:0] o, output logic [W-1:0] q,
                                output logic [W-1:0] r, output int lat);
    longint sa, sb, sq, sr, ma, mb;
    if (b == '0) begin
      q = '1; r = a; lat = 2;
    end else if (o[1]) begin
      q = a / b; r = a % b; lat = (a < b) ? 2 : W + 2;
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      sq = sa / sb;
      sr = sa % sb;
      q  = sq[W-1:0];
      r  = sr[W-1:0];
      ma = (sa < 0) ? -sa : sa;
      mb = (sb < 0) ? -sb : sb;
      lat = (ma < mb) ? 2 : W + 2;
    end
  endfunction

  // driver: pushes the expected result, holds start across one rising edge
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [1:0] o, output int lat);
    logic [W-1:0] q, r;
    model(a, b, o, q, r, lat);
    exp_q.push_back({q, r});
    start = 1'b1; dividend = a; divisor = b; op = o;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Waits for done, counting cycles from the start cycle; optionally pokes a
  // stray start at cycle 'poke' that must be ignored.
  task automatic wait_done(input int lat, input string tag, input int poke);
    int cyc;
    bit seen, bad;
    logic [2*W-1:0] e;
    cyc = 0; seen = 1'b0; bad = 1'b0;
    while (!seen && cyc < 200) begin
      @(negedge clk);
      cyc++;
      if (cyc == poke) begin
        start = 1'b1; dividend = $urandom; divisor = $urandom_range(1, 9); op = 2'b10;
      end
      if (cyc == poke + 1) start = 1'b0;
      if (done) seen = 1'b1;
      else begin
        if (is_running !== 1'b1) bad = 1'b1;
        if ({quotient_out, remainder_out} !== {last_q, last_r}) bad = 1'b1;
      end
    end
    check({tag, "_lat"}, 64'(cyc), 64'(lat));
    check({tag, "_ctl"}, {63'd0, bad}, 64'd0);
    check({tag, "_run_at_done"}, {63'd0, is_running}, 64'd0);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
    check({tag, "_q"}, 64'(quotient_out), 64'(e[2*W-1:W]));
    check({tag, "_r"}, 64'(remainder_out), 64'(e[W-1:0]));
    last_q = e[2*W-1:W];
    last_r = e[W-1:0];
  endtask

  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [1:0] o, input string tag);
    int lat;
    @(posedge clk);
    #1;
    issue(a, b, o, lat);
    wait_done(lat, tag, 0);
  endtask

  initial begin
    int lat;
    logic [W-1:0] a, b;
    logic [1:0] o;
    bit bad;
    checks = 0; failures = 0;
    last_q = '0; last_r = '0;
    rst_n = 1'b0; start = 1'b0; flush = 1'b0; op = 2'b00;
    dividend = '0; divisor = '0;
    #2;
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_run", {63'd0, is_running}, 64'd0);
    check("rst_q", 64'(quotient_out), 64'd0);
    check("rst_r", 64'(remainder_out), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // directed cases
    run_op(32'd100, 32'd7, 2'b10, "u100_7");
    run_op(32'hFFFFFFF9, 32'd2, 2'b00, "s_m7_2");
    run_op(32'hFFFFFFF9, 32'd2, 2'b11, "u_big_2");
    run_op(32'h80000000, 32'hFFFFFFFF, 2'b01, "s_min_m1");
    run_op(32'h12345678, 32'd0, 2'b10, "u_div0");
    run_op(32'h12345678, 32'd0, 2'b00, "s_div0");
    run_op(32'd3, 32'hFFFFFFFB, 2'b01, "s_early");
    run_op(32'd5, 32'd5, 2'b10, "u_equal");
    run_op(32'hFFFFFFFF, 32'd1, 2'b10, "u_max_1");

    // stray start while running must not disturb the result
    @(posedge clk);
    #1;
    issue(32'd1000, 32'd3, 2'b10, lat);
    wait_done(lat, "poke", 12);

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = $urandom_range(1, 255);
        2: b = 32'(0) - $urandom_range(1, 255);
        3: b = '0;
        default: b = $urandom >> $urandom_range(0, 31);
      endcase
      o = 2'($urandom_range(0, 3));
      run_op(a, b, o, "rand");
    end

    // flush at T+10, new start at T+11
    @(posedge clk);
    #1;
    issue(32'd999999, 32'd13, 2'b10, lat);
    bad = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (done) bad = 1'b1;
      if (c == 10) flush = 1'b1;
    end
    @(negedge clk);
    flush = 1'b0;
    check("flush_no_done", {63'd0, bad | done}, 64'd0);
    check("flush_run", {63'd0, is_running}, 64'd0);
    check("flush_hold", {quotient_out, remainder_out}, {last_q, last_r});
    void'(exp_q.pop_back());
    issue(32'hDEADBEEF, 32'hFFFF0001, 2'b00, lat);
    wait_done(lat, "post_flush", 0);

    // back-to-back start in DONE
    @(posedge clk);
    #1;
    issue(32'd77777, 32'd77, 2'b10, lat);
    wait_done(lat, "b2b_a", 0);
    issue(32'h7FFFFFFF, 32'hFFFFFFFD, 2'b00, lat);
    wait_done(lat, "b2b_b", 0);

    // reset at T+5 mid-operation
    @(posedge clk);
    #1;
    issue(32'd123456, 32'd10, 2'b10, lat);
    bad = 1'b0;
    for (int c = 1; c < 5; c++) begin
      @(negedge clk);
      if (done) bad = 1'b1;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_done", {63'd0, bad | done}, 64'd0);
    check("mid_rst_run", {63'd0, is_running}, 64'd0);
    check("mid_rst_q", 64'(quotient_out), 64'd0);
    check("mid_rst_r", 64'(remainder_out), 64'd0);
    void'(exp_q.pop_back());
    last_q = '0; last_r = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run_op(32'd100, 32'd7, 2'b10, "after_rst");

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/iter_divider.md
ITER_DIVIDER -- requirements
Module: iter_divider

Interface
REQ-001 Parameter WIDTH, default 32, operand/result width in bits; legal range 4..64.
REQ-002 Parameter EARLY_OUT, default 1, enables the |dividend| < |divisor| fast path.
REQ-003 clk  input  1  sole clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request strobe, sampled each cycle.
REQ-006 op  input  2  op[1]=0 signed, op[1]=1 unsigned; op[0] is don't-care (both results are always produced).
REQ-007 dividend, divisor  input  WIDTH  operands, sampled with start.
REQ-008 flush  input  1  cancels any operation in progress.
REQ-009 is_running  output  1  high while an accepted operation is in progress.
REQ-010 done  output  1  single-cycle pulse marking valid results.
REQ-011 quotient_out, remainder_out  output  WIDTH  results, held stable until the next done.

Function
REQ-012 The block SHALL use states IDLE, CALC, FIX, DONE.
REQ-013 start SHALL be accepted only in IDLE or DONE with flush low; start in CALC or FIX SHALL be ignored.
REQ-014 On acceptance the block SHALL latch operands and op, and compute absolute values when op[1]=0.
REQ-015 Divisor zero: the block SHALL go to DONE next cycle with quotient all ones and remainder = dividend; done at T+2 for start at T.
REQ-016 If EARLY_OUT=1 and |dividend| < |divisor| (unsigned compare of magnitudes), the block SHALL go to DONE next cycle with quotient 0 and remainder = dividend; done at T+2.
REQ-017 Otherwise the block SHALL enter CALC and perform radix-2 restoring division, one quotient bit per cycle, for exactly WIDTH cycles, tracked by a $clog2(WIDTH)+1-bit counter.
REQ-018 FIX SHALL last one cycle: negate quotient if operand signs differ (signed mode); negate remainder if dividend negative (signed mode).
REQ-019 done SHALL assert in DONE, i.e. cycle T+WIDTH+2 for the normal path (T+34 at WIDTH=32); DONE SHALL return to IDLE next cycle unless a new start is accepted.
REQ-020 quotient_out/remainder_out SHALL update only on the cycle done asserts.
REQ-021 is_running SHALL be high in CALC and FIX, low in IDLE and DONE.
REQ-022 Signed most-negative / -1 SHALL yield quotient = most-negative value, remainder 0 (two's-complement wrap), no special flag.
REQ-023 flush SHALL force IDLE on the next edge from any state, suppress done, and leave result outputs unchanged; flush and start in the same cycle: flush wins, start dropped.
REQ-024 Start accepted in DONE SHALL proceed as from IDLE; done still pulses for the finishing operation.

Reset
REQ-025 rst_n low SHALL immediately force IDLE, counter 0, is_running 0, done 0, quotient_out 0, remainder_out 0, independent of clk.
REQ-026 Reset asserted mid-operation SHALL abort it with no done pulse; first start after rst_n rises is accepted on the first clock edge.

Verification (WIDTH=32)
REQ-027 Unsigned 100/7 started at T -> is_running T+1..T+33, done at T+34, q=14, r=2.
REQ-028 Signed 0xFFFFFFF9/2 (-7/2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
REQ-029 0x12345678/0 (either mode) -> done at T+2, q=0xFFFFFFFF, r=0x12345678; signed 3/0xFFFFFFFB -> done at T+2, q=0, r=3.
REQ-030 flush at T+10 of a normal op -> no done, is_running low at T+11; new start at T+11 accepted, correct done at T+45.
REQ-031 rst_n low at T+5 mid-op -> outputs zero immediately, no done; start during running ignored with results unaffected; back-to-back start in DONE -> two done pulses WIDTH+2 cycles apart.
